word_packer: RTL and testbench

//   Width up-converter placed directly downstream of the channel skid buffer.

---
 rtl/word_packer.sv | 122 ++++++++++++
 tb/tb_word_packer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_packer.sv
// rtl/word_packer.sv - width up-converter packing RATIO narrow words into one wide word
//
// Packs RATIO consecutive WIDTH-bit input words into one WIDTH*RATIO-bit
// output word.  An input word flagged with i_last closes the packet early.
// In that case the unused upper lanes of the output word are zero.
// One input word per cycle is sustained while o_rdy stays high.
//
// Ports:
//   clk     - clock, all state updates on posedge
//   rst     - asynchronous active-high reset
//   i_val   - input word valid
//   i_rdy   - input word accepted when i_val && i_rdy
//   i_data  - input word
//   i_last  - input word is the final word of a packet
//   o_val   - output word valid
//   o_rdy   - downstream accepts when o_val && o_rdy
//   o_data  - packed word, first input word in bits [WIDTH-1:0]
//   o_cnt   - number of valid lanes in o_data (1..RATIO)
//   o_last  - output word closes a packet
module word_packer #(
    parameter int WIDTH = 32,
    parameter int RATIO = 8,
    localparam int CW = $clog2(RATIO + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_val,
    output logic                   i_rdy,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_last,
    output logic                   o_val,
    input  logic                   o_rdy,
    output logic [WIDTH*RATIO-1:0] o_data,
    output logic [CW-1:0]          o_cnt,
    output logic                   o_last
);

    localparam int LW = $clog2(RATIO);

    logic [WIDTH*RATIO-1:0] acc;
    logic [LW-1:0]          lane;
    logic                   pend;
    logic [CW-1:0]          pend_cnt;
    logic                   pend_last;

    logic [WIDTH*RATIO-1:0] word_in;
    logic [CW-1:0]          lane_cnt;
    logic                   accept;
    logic                   complete;
    logic                   slot_free;

    // i_rdy depends only on local state so it never forms a combinational
    // path from o_rdy or i_val.
    assign i_rdy     = !rst && !pend;
    assign accept    = i_val && i_rdy;
    assign complete  = accept && ((lane == LW'(RATIO - 1)) || i_last);
    assign slot_free = !o_val || o_rdy;
    assign lane_cnt  = CW'(lane) + CW'(1);

    // Accumulator with the incoming word merged into the current lane.
    // Lanes above the current one are already zero because acc is cleared
    // whenever a word is completed or handed to the output register.
    always_comb begin
        word_in = acc;
        for (int i = 0; i < RATIO; i++) begin
            if (LW'(i) == lane) begin
                word_in[i*WIDTH +: WIDTH] = i_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            lane      <= '0;
            pend      <= 1'b0;
            pend_cnt  <= '0;
            pend_last <= 1'b0;
            o_val     <= 1'b0;
            o_data    <= '0;
            o_cnt     <= '0;
            o_last    <= 1'b0;
        end else begin
            // Drain; overridden below when a new word is loaded this edge.
            if (o_val && o_rdy) begin
                o_val <= 1'b0;
            end

            if (pend) begin
                // Completed word parked in acc; no input is accepted meanwhile.
                if (slot_free) begin
                    o_val  <= 1'b1;
                    o_data <= acc;
                    o_cnt  <= pend_cnt;
                    o_last <= pend_last;
                    acc    <= '0;
                    pend   <= 1'b0;
                end
            end else if (accept) begin
                if (complete) begin
                    lane <= '0;
                    if (slot_free) begin
                        o_val  <= 1'b1;
                        o_data <= word_in;
                        o_cnt  <= lane_cnt;
                        o_last <= i_last;
                        acc    <= '0;
                    end else begin
                        acc       <= word_in;
                        pend      <= 1'b1;
                        pend_cnt  <= lane_cnt;
                        pend_last <= i_last;
                    end
                end else begin
                    acc  <= word_in;
                    lane <= lane + LW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_word_packer.sv
// tb/tb_word_packer.sv - self-checking bench for word_packer (WIDTH=8, RATIO=4)
module tb_word_packer;

    logic        clk;
    logic        rst;
    logic        i_val;
    logic        i_rdy;
    logic [7:0]  i_data;
    logic        i_last;
    logic        o_val;
    logic        o_rdy;
    logic [31:0] o_data;
    logic [2:0]  o_cnt;
    logic        o_last;

    int checks;
    int failures;

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  c;
        logic        l;
    } exp_t;

    word_packer #(.WIDTH(8), .RATIO(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_val  (i_val),
        .i_rdy  (i_rdy),
        .i_data (i_data),
        .i_last (i_last),
        .o_val  (o_val),
        .o_rdy  (o_rdy),
        .o_data (o_data),
        .o_cnt  (o_cnt),
        .o_last (o_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, required finish before 2ms");
        $fatal(1);
    end

    // Present one word and hold it until i_rdy is seen; returns at the negedge
    // before the accepting posedge.
    task automatic send(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        i_val  = 1'b1;
        i_data = d;
        i_last = last;
        @(negedge clk);
        while (!i_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!i_rdy) begin
            checks++;
            failures++;
            $display("FAIL send_timeout i_rdy=%0b required 1", i_rdy);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        i_val  = 1'b0;
        i_last = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        i_val  = 1'b1;
        i_data = 8'hFF;
        i_last = 1'b0;
        o_rdy  = 1'b1;
        @(negedge clk);
        checks++; if (i_rdy !== 1'b0) begin failures++; $display("FAIL reset_i_rdy got=%0b exp=0", i_rdy); end
        checks++; if (o_val !== 1'b0) begin failures++; $display("FAIL reset_o_val got=%0b exp=0", o_val); end
        checks++; if (o_data !== 32'h0 || o_cnt !== 3'd0 || o_last !== 1'b0) begin
            failures++; $display("FAIL reset_out got=%h/%0d/%0b exp=0/0/0", o_data, o_cnt, o_last);
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        i_val = 1'b0;
        @(negedge clk);
        checks++; if (i_rdy !== 1'b1) begin failures++; $display("FAIL release_i_rdy got=%0b exp=1", i_rdy); end
        checks++; if (o_val !== 1'b0) begin failures++; $display("FAIL release_o_val got=%0b exp=0", o_val); end
    endtask

    task automatic test_full_word();
        o_rdy = 1'b1;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        checks++; if (o_val !== 1'b0) begin failures++; $display("FAIL full_early_o_val got=%0b exp=0", o_val); end
        idle();
        @(negedge clk);
        checks++; if (o_val !== 1'b1 || o_data !== 32'h04030201 || o_cnt !== 3'd4 || o_last !== 1'b0) begin
            failures++; $display("FAIL full_word got=%0b/%h/%0d/%0b exp=1/04030201/4/0", o_val, o_data, o_cnt, o_last);
        end
        @(negedge clk);
        checks++; if (o_val !== 1'b0) begin failures++; $display("FAIL full_drain o_val got=%0b exp=0", o_val); end
    endtask

    task automatic test_last_early();
        o_rdy = 1'b1;
        send(8'h0A, 1'b0);
        send(8'h0B, 1'b1);
        idle();
        @(negedge clk);
        checks++; if (o_val !== 1'b1 || o_data !== 32'h00000B0A || o_cnt !== 3'd2 || o_last !== 1'b1) begin
            failures++; $display("FAIL last_early got=%0b/%h/%0d/%0b exp=1/00000b0a/2/1", o_val, o_data, o_cnt, o_last);
        end
        send(8'h0C, 1'b1);
        idle();
        @(negedge clk);
        checks++; if (o_val !== 1'b1 || o_data !== 32'h0000000C || o_cnt !== 3'd1 || o_last !== 1'b1) begin
            failures++; $display("FAIL last_lane0 got=%0b/%h/%0d/%0b exp=1/0000000c/1/1", o_val, o_data, o_cnt, o_last);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        o_rdy = 1'b0;
        for (int d = 0; d < 8; d++) begin
            send(8'(d), 1'b0);
        end
        idle();
        @(negedge clk);
        checks++; if (i_rdy !== 1'b0) begin failures++; $display("FAIL bp_i_rdy_low got=%0b exp=0", i_rdy); end
        checks++; if (o_val !== 1'b1 || o_data !== 32'h03020100 || o_cnt !== 3'd4) begin
            failures++; $display("FAIL bp_first got=%0b/%h/%0d exp=1/03020100/4", o_val, o_data, o_cnt);
        end
        repeat (3) @(negedge clk);
        checks++; if (o_val !== 1'b1 || o_data !== 32'h03020100) begin
            failures++; $display("FAIL bp_hold got=%0b/%h exp=1/03020100", o_val, o_data);
        end
        @(posedge clk);
        #1;
        o_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (o_val !== 1'b1 || o_data !== 32'h07060504 || o_cnt !== 3'd4 || o_last !== 1'b0) begin
            failures++; $display("FAIL bp_second got=%0b/%h/%0d/%0b exp=1/07060504/4/0", o_val, o_data, o_cnt, o_last);
        end
        checks++; if (i_rdy !== 1'b1) begin failures++; $display("FAIL bp_i_rdy_back got=%0b exp=1", i_rdy); end
        @(negedge clk);
        checks++; if (o_val !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0b exp=0", o_val); end
    endtask

    task automatic test_stream();
        logic [31:0] q[$];
        logic [31:0] cur;
        logic [31:0] e;
        int n, sent, got, stalls;
        cur = '0; n = 0; sent = 0; got = 0; stalls = 0;
        o_rdy = 1'b1;
        for (int c = 0; c < 4010; c++) begin
            @(posedge clk);
            #1;
            i_last = 1'b0;
            if (sent < 4000) begin
                i_val  = 1'b1;
                i_data = 8'($urandom);
            end else begin
                i_val = 1'b0;
            end
            @(negedge clk);
            if (o_val && o_rdy) begin
                got++;
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL stream_extra got=%h exp=none", o_data);
                end else begin
                    e = q.pop_front();
                    if (o_data !== e || o_cnt !== 3'd4 || o_last !== 1'b0) begin
                        failures++; $display("FAIL stream_word got=%h/%0d/%0b exp=%h/4/0", o_data, o_cnt, o_last, e);
                    end
                end
            end
            if (i_val) begin
                if (i_rdy) begin
                    cur[n*8 +: 8] = i_data;
                    n++;
                    sent++;
                    if (n == 4) begin
                        q.push_back(cur);
                        cur = '0;
                        n = 0;
                    end
                end else begin
                    stalls++;
                end
            end
        end
        checks++; if (stalls !== 0) begin failures++; $display("FAIL stream_stalls got=%0d exp=0", stalls); end
        checks++; if (got !== 1000) begin failures++; $display("FAIL stream_count got=%0d exp=1000", got); end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        logic [31:0] cur;
        int n;
        bit rst_done;
        cur = '0; n = 0; rst_done = 1'b0;
        for (int c = 0; c < 10020; c++) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            if (c < 10000) begin
                i_val  = ($urandom_range(0, 3) != 0);
                i_data = 8'($urandom);
                i_last = ($urandom_range(0, 7) == 0);
                o_rdy  = ($urandom_range(0, 9) < 7);
                if (c >= 5000 && !rst_done && n > 0) begin
                    rst = 1'b1;
                    rst_done = 1'b1;
                end
            end else begin
                i_val  = 1'b0;
                i_last = 1'b0;
                o_rdy  = 1'b1;
            end
            @(negedge clk);
            if (rst) begin
                checks++;
                if (o_val !== 1'b0 || i_rdy !== 1'b0) begin
                    failures++; $display("FAIL rand_reset got=%0b/%0b exp=0/0", o_val, i_rdy);
                end
                q.delete();
                cur = '0;
                n = 0;
            end else begin
                if (o_val && o_rdy) begin
                    checks++;
                    if (q.size() == 0) begin
                        failures++; $display("FAIL rand_extra got=%h/%0d/%0b exp=none", o_data, o_cnt, o_last);
                    end else begin
                        e = q.pop_front();
                        if (o_data !== e.d || o_cnt !== e.c || o_last !== e.l) begin
                            failures++;
                            $display("FAIL rand_word got=%h/%0d/%0b exp=%h/%0d/%0b", o_data, o_cnt, o_last, e.d, e.c, e.l);
                        end
                    end
                end
                if (i_val && i_rdy) begin
                    cur[n*8 +: 8] = i_data;
                    n++;
                    if (n == 4 || i_last) begin
                        q.push_back({cur, 3'(n), i_last});
                        cur = '0;
                        n = 0;
                    end
                end
            end
        end
        checks++; if (q.size() !== 0) begin failures++; $display("FAIL rand_missing got=%0d exp=0", q.size()); end
        checks++; if (rst_done !== 1'b1) begin failures++; $display("FAIL rand_no_reset got=%0b exp=1", rst_done); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        i_val    = 1'b0;
        i_data   = 8'h00;
        i_last   = 1'b0;
        o_rdy    = 1'b0;
        test_reset();
        test_full_word();
        test_last_early();
        test_backpressure();
        test_stream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
